// File: rtl/or_seq_pkg.sv
// Shared types for the OR-datapath stimulus sequencer: FSM state encoding,
// the default step-table entry layout and the error-count ceiling.
package or_seq_pkg;

  localparam int DEF_WIDTH   = 1;
  localparam int DEF_DWELL_W = 8;

  // err_cnt stops here instead of wrapping back to zero
  localparam logic [7:0] ERR_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Entry layout at the default widths; the table is typed by a parameter so
  // the top can hand it a layout sized to its own WIDTH/DWELL_W.
  typedef struct packed {
    logic [DEF_WIDTH-1:0]   a;
    logic [DEF_WIDTH-1:0]   b;
    logic [DEF_DWELL_W-1:0] dwell;
  } step_t;

  // Saturating increment for the failed-step counter
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/or_stim_sequencer_if.sv
// Bus between a bench (master) and the stimulus sequencer (slave).
// Optional FORCE_OVR_EN adds frc_en/frc_val, an override of the observed value.
//
// Signalling: there is no valid/ready pair on this bus. start and abort are
// single-cycle pulses sampled on the rising clock edge; cfg_we writes one table
// entry per cycle it is high and is silently dropped while busy=1. obs_c is
// sampled only on a step's final dwell cycle; mismatch is a 1-cycle pulse.
interface or_stim_sequencer_if #(
  parameter int WIDTH   = 1,
  parameter int DWELL_W = 8,
  parameter int AW      = 2
);

  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [WIDTH-1:0]   cfg_a;
  logic [WIDTH-1:0]   cfg_b;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   obs_c;
  logic [WIDTH-1:0]   drv_a;
  logic [WIDTH-1:0]   drv_b;
  logic               busy;
  logic               done;
  logic               mismatch;
  logic [7:0]         err_cnt;
`ifdef FORCE_OVR_EN
  logic               frc_en;
  logic [WIDTH-1:0]   frc_val;
`endif

  modport master (
    output cfg_we, cfg_addr, cfg_a, cfg_b, cfg_dwell, start, abort, obs_c,
`ifdef FORCE_OVR_EN
    output frc_en, frc_val,
`endif
    input  drv_a, drv_b, busy, done, mismatch, err_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_a, cfg_b, cfg_dwell, start, abort, obs_c,
`ifdef FORCE_OVR_EN
    input  frc_en, frc_val,
`endif
    output drv_a, drv_b, busy, done, mismatch, err_cnt
  );

endinterface

// File: rtl/or_seq_step_table.sv
// NUM_STEPS-deep register file of step entries: one synchronous write port,
// one combinational read port, every entry cleared by the async reset.
module or_seq_step_table
  import or_seq_pkg::*;
#(
  parameter int  NUM_STEPS = 4,
  parameter int  AW        = 2,
  parameter type entry_t   = step_t
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_data
);

  entry_t mem [NUM_STEPS];
  logic   addr_ok;

  // Addresses past the table end are dropped rather than aliased
  assign addr_ok = (32'(wr_addr) < 32'(NUM_STEPS));

  // Entry storage: cleared on reset, written one entry per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) mem[i] <= '0;
    end else if (wr_en && addr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/or_stim_sequencer.sv
// Programmable stimulus sequencer and checker for an a|b OR datapath.
// Walks the step table, drives drv_a/drv_b for 1 + max(dwell,1) cycles per
// step and compares the returned value with a|b on each step's last cycle.
// Optional macro: FORCE_OVR_EN (checker uses frc_val while frc_en=1).
module or_stim_sequencer
  import or_seq_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DWELL_W   = DEF_DWELL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  or_stim_sequencer_if.slave   bus,
  output state_e               dbg_state
);

  localparam int AW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  typedef struct packed {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [DWELL_W-1:0] dwell;
  } entry_t;

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   drv_a_q, drv_a_d;
  logic [WIDTH-1:0]   drv_b_q, drv_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mis_q, mis_d;
  logic [7:0]         err_q, err_d;

  entry_t             wr_data;
  entry_t             rd_data;
  logic [WIDTH-1:0]   chk_val;
  logic [WIDTH-1:0]   exp_val;
  logic [DWELL_W-1:0] dwell_eff;
  logic               last_step;

  // Table writes are locked out for the whole run so a step never changes
  // underneath the checker.
  assign wr_data = {bus.cfg_a, bus.cfg_b, bus.cfg_dwell};

  or_seq_step_table #(
    .NUM_STEPS (NUM_STEPS),
    .AW        (AW),
    .entry_t   (entry_t)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.cfg_we && !busy_q),
    .wr_addr (bus.cfg_addr),
    .wr_data (wr_data),
    .rd_addr (idx_q),
    .rd_data (rd_data)
  );

`ifdef FORCE_OVR_EN
  assign chk_val = bus.frc_en ? bus.frc_val : bus.obs_c;
`else
  assign chk_val = bus.obs_c;
`endif

  // idx_q is stable through a step, so rd_data is the step being checked
  assign exp_val   = rd_data.a | rd_data.b;
  assign dwell_eff = (rd_data.dwell == '0) ? DWELL_W'(1) : rd_data.dwell;
  assign last_step = (32'(idx_q) == 32'(NUM_STEPS - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      drv_a_q <= '0;
      drv_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drv_a_q <= drv_a_d;
      drv_b_q <= drv_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // Next-state, step sequencing and check logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drv_a_d = drv_a_q;
    drv_b_d = drv_b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mis_d   = 1'b0;
    err_d   = err_q;

    if (bus.abort) begin
      // err_cnt deliberately survives an abort so the partial run can be read
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      drv_a_d = '0;
      drv_b_d = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = APPLY;
            idx_d   = '0;
            err_d   = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        APPLY: begin
          drv_a_d = rd_data.a;
          drv_b_d = rd_data.b;
          cnt_d   = dwell_eff;
          state_d = DWELL;
        end
        DWELL: begin
          cnt_d = cnt_q - DWELL_W'(1);
          if (cnt_q == DWELL_W'(1)) begin
            if (chk_val != exp_val) begin
              mis_d = 1'b1;
              err_d = sat_inc(err_q);
            end
            if (last_step) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = APPLY;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.drv_a    = drv_a_q;
  assign bus.drv_b    = drv_b_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mismatch = mis_q;
  assign bus.err_cnt  = err_q;
  assign dbg_state    = state_q;

endmodule
